// File: rtl/dsp_post_adder_acc_pkg.sv
// rtl/dsp_post_adder_acc_pkg.sv - opmode field layout and operand select encodings
package dsp_post_adder_acc_pkg;

  localparam int PWIDTH_DEF = 48;
  localparam int MWIDTH_DEF = 36;

  localparam int OP_XSEL_LSB  = 0;
  localparam int OP_ZSEL_LSB  = 2;
  localparam int OP_CIN_CONST = 4;
  localparam int OP_CIN_SRC   = 5;
  localparam int OP_RSVD      = 6;
  localparam int OP_SUB       = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_post_adder_acc_dff_mux.sv
// rtl/dsp_post_adder_acc_dff_mux.sv - register/bypass cell with synchronous reset
module dsp_post_adder_acc_dff_mux #(
  parameter int WIDTH = 1,
  parameter int SEL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] reg_out
);

  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  always_comb begin
    reg_d = reg_q;
    if (rst) begin
      reg_d = '0;
    end else if (ce) begin
      reg_d = d;
    end
  end

  always_ff @(posedge clk) begin
    reg_q <= reg_d;
  end

  // reg_out always exposes the flop, even when q bypasses it
  assign reg_out = reg_q;
  assign q       = (SEL != 0) ? reg_q : d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// rtl/dsp_post_adder_acc.sv - DSP post-adder/accumulator with P feedback and cascade out
module dsp_post_adder_acc
  import dsp_post_adder_acc_pkg::*;
#(
  parameter int PWIDTH      = PWIDTH_DEF,
  parameter int MWIDTH      = MWIDTH_DEF,
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_opmode,
  input  logic              ce_carryin,
  input  logic              ce_p,
  input  logic [7:0]        opmode,
  input  logic [MWIDTH-1:0] m,
  input  logic [PWIDTH-1:0] dab,
  input  logic [PWIDTH-1:0] c,
  input  logic [PWIDTH-1:0] pcin,
  input  logic              carryin,
  output logic [PWIDTH-1:0] p,
  output logic [PWIDTH-1:0] pcout,
  output logic              carryout,
  output logic              carryoutf
);

  logic [7:0]        opmode_in;
  logic [7:0]        opmode_eff;
  logic [7:0]        unused_opmode_reg;
  logic              cin_sel;
  logic              cin_eff;
  logic              unused_cyi_reg;
  logic [PWIDTH-1:0] p_fb;
  logic              unused_co_reg;
  logic              unused_rsvd;
  x_sel_e            x_sel;
  z_sel_e            z_sel;
  logic [PWIDTH-1:0] x_op;
  logic [PWIDTH-1:0] z_op;
  logic [PWIDTH:0]   sum;

  // The reserved bit is dropped before the register so it can never reach the datapath
  always_comb begin
    opmode_in          = opmode;
    opmode_in[OP_RSVD] = 1'b0;
  end

  dsp_post_adder_acc_dff_mux #(.WIDTH(8), .SEL(OPMODEREG)) u_opmode_reg (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce_opmode),
    .d       (opmode_in),
    .q       (opmode_eff),
    .reg_out (unused_opmode_reg)
  );

  // Carry select follows the live opmode so cyi lines up with the registered opmode
  assign cin_sel = opmode[OP_CIN_SRC] ? carryin : opmode[OP_CIN_CONST];

  dsp_post_adder_acc_dff_mux #(.WIDTH(1), .SEL(CARRYINREG)) u_cyi_reg (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce_carryin),
    .d       (cin_sel),
    .q       (cin_eff),
    .reg_out (unused_cyi_reg)
  );

  assign unused_rsvd = opmode_eff[OP_RSVD];

  always_comb begin
    x_sel = x_sel_e'(opmode_eff[OP_XSEL_LSB +: 2]);
    z_sel = z_sel_e'(opmode_eff[OP_ZSEL_LSB +: 2]);

    x_op = '0;
    case (x_sel)
      X_ZERO:  x_op = '0;
      X_M:     x_op = {{(PWIDTH-MWIDTH){1'b0}}, m};
      X_P:     x_op = p_fb;
      X_DAB:   x_op = dab;
      default: x_op = '0;
    endcase

    z_op = '0;
    case (z_sel)
      Z_ZERO:  z_op = '0;
      Z_PCIN:  z_op = pcin;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = c;
      default: z_op = '0;
    endcase

    // MSB of the widened result is carry on add and borrow on subtract
    if (opmode_eff[OP_SUB]) begin
      sum = {1'b0, z_op} - ({1'b0, x_op} + {{PWIDTH{1'b0}}, cin_eff});
    end else begin
      sum = {1'b0, z_op} + {1'b0, x_op} + {{PWIDTH{1'b0}}, cin_eff};
    end
  end

  dsp_post_adder_acc_dff_mux #(.WIDTH(PWIDTH), .SEL(PREG)) u_p_reg (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce_p),
    .d       (sum[PWIDTH-1:0]),
    .q       (p),
    .reg_out (p_fb)
  );

  dsp_post_adder_acc_dff_mux #(.WIDTH(1), .SEL(CARRYOUTREG)) u_carryout_reg (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce_p),
    .d       (sum[PWIDTH]),
    .q       (carryout),
    .reg_out (unused_co_reg)
  );

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb/tb_dsp_post_adder_acc.sv - self-checking bench for dsp_post_adder_acc
module tb_dsp_post_adder_acc;

  localparam int PW = 48;
  localparam int MW = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce_opmode = 1'b1;
  logic          ce_carryin = 1'b1;
  logic          ce_p = 1'b1;
  logic [7:0]    opmode = 8'h00;
  logic [MW-1:0] m = '0;
  logic [PW-1:0] dab = '0;
  logic [PW-1:0] c = '0;
  logic [PW-1:0] pcin = '0;
  logic          carryin = 1'b0;

  logic [PW-1:0] p, pcout, p2, pcout2;
  logic          carryout, carryoutf, carryout2, carryoutf2;

  int tests_run = 0;
  int tests_failed = 0;

  dsp_post_adder_acc dut (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
  );

  dsp_post_adder_acc #(.PREG(0)) dut_bypass (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p2), .pcout(pcout2), .carryout(carryout2), .carryoutf(carryoutf2)
  );

  always #5 clk = ~clk;

  // Reference state: opmode in effect, registered carry-in, accumulator, carry flag
  logic [7:0]    mdl_op  = 8'h00;
  logic          mdl_cyi = 1'b0;
  logic [PW-1:0] mdl_p   = '0;
  logic          mdl_co  = 1'b0;

  function automatic logic [PW:0] ref_calc();
    longint unsigned x, z, t, s, modv;
    logic cy;
    modv = 64'd1 << PW;
    case (mdl_op[1:0])
      2'd0: x = 0;
      2'd1: x = 64'(m);
      2'd2: x = 64'(mdl_p);
      default: x = 64'(dab);
    endcase
    case (mdl_op[3:2])
      2'd0: z = 0;
      2'd1: z = 64'(pcin);
      2'd2: z = 64'(mdl_p);
      default: z = 64'(c);
    endcase
    if (mdl_op[7]) begin
      t = x + 64'(mdl_cyi);
      if (z >= t) begin s = z - t; cy = 1'b0; end
      else begin s = z + modv - t; cy = 1'b1; end
    end else begin
      s = z + x + 64'(mdl_cyi);
      cy = (s >= modv);
      if (cy) s = s - modv;
    end
    return {cy, s[PW-1:0]};
  endfunction

  always @(posedge clk) begin
    logic [PW:0] r;
    r = ref_calc();
    if (rst) begin
      mdl_op = 8'h00; mdl_cyi = 1'b0; mdl_p = '0; mdl_co = 1'b0;
    end else begin
      if (ce_p) {mdl_co, mdl_p} = r;
      if (ce_carryin) mdl_cyi = opmode[5] ? carryin : opmode[4];
      if (ce_opmode) mdl_op = opmode;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
    opmode = 8'h00; carryin = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
    m = 36'd5; opmode = 8'h01; carryin = 1'b0;
    dab = 48'h1234; c = 48'h777; pcin = 48'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (p !== '0 || pcout !== '0) begin
        tests_failed++; $display("FAIL reset_p[%0d] got p=%0d pcout=%0d exp 0", i, p, pcout);
      end
      tests_run++;
      if (carryout !== 1'b0 || carryoutf !== 1'b0) begin
        tests_failed++; $display("FAIL reset_co[%0d] got %b/%b exp 0", i, carryout, carryoutf);
      end
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (p !== '0 || carryout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release got p=%0d co=%b exp 0/0", p, carryout);
    end
    tick();
    tests_run++;
    if (p !== 48'd5) begin
      tests_failed++; $display("FAIL reset_first_data got %0d exp 5", p);
    end
  endtask

  task automatic test_mac();
    do_reset();
    opmode = 8'h09; m = 36'd3; carryin = 1'b0;
    tick();
    tests_run++;
    if (p !== '0) begin
      tests_failed++; $display("FAIL mac_align got %0d exp 0", p);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (p !== 48'(3 * k) || pcout !== 48'(3 * k) || carryout !== 1'b0) begin
        tests_failed++; $display("FAIL mac_p[%0d] got %0d co=%b exp %0d", k, p, carryout, 3 * k);
      end
    end
  endtask

  task automatic test_enable_hold();
    ce_p = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (p !== 48'd12) begin
        tests_failed++; $display("FAIL hold_p[%0d] got %0d exp 12", i, p);
      end
    end
    ce_p = 1'b1;
    tick();
    tests_run++;
    if (p !== 48'd15) begin
      tests_failed++; $display("FAIL hold_resume got %0d exp 15", p);
    end
    ce_opmode = 1'b0; opmode = 8'h0f; c = 48'd1000; dab = 48'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (p !== 48'(18 + 3 * i)) begin
        tests_failed++; $display("FAIL hold_opmode[%0d] got %0d exp %0d", i, p, 18 + 3 * i);
      end
    end
    ce_opmode = 1'b1;
  endtask

  task automatic test_subtract();
    do_reset();
    opmode = 8'h8d; c = 48'd5; m = 36'd7;
    tick(); tick();
    tests_run++;
    if (p !== 48'hFFFF_FFFF_FFFE || carryout !== 1'b1 || carryoutf !== 1'b1) begin
      tests_failed++; $display("FAIL sub_borrow got p=%h co=%b exp fffffffffffe/1", p, carryout);
    end
    c = 48'd7; m = 36'd5;
    tick();
    tests_run++;
    if (p !== 48'd2 || carryout !== 1'b0) begin
      tests_failed++; $display("FAIL sub_noborrow got p=%0d co=%b exp 2/0", p, carryout);
    end
  endtask

  task automatic test_wrap_carry();
    do_reset();
    opmode = 8'h0f; c = {PW{1'b1}}; dab = 48'd1;
    tick(); tick();
    tests_run++;
    if (p !== '0 || carryout !== 1'b1) begin
      tests_failed++; $display("FAIL wrap got p=%0d co=%b exp 0/1", p, carryout);
    end
    opmode = 8'h2f; carryin = 1'b1; dab = '0; c = 48'd5;
    tick();
    tests_run++;
    if (p !== 48'd5 || carryout !== 1'b0) begin
      tests_failed++; $display("FAIL cin_pre got p=%0d co=%b exp 5/0", p, carryout);
    end
    tick();
    tests_run++;
    if (p !== 48'd6) begin
      tests_failed++; $display("FAIL cin_late got %0d exp 6", p);
    end
    carryin = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    opmode = 8'h04; pcin = 48'd100;
    tick();
    tests_run++;
    if (p2 !== 48'd100 || pcout2 !== 48'd100) begin
      tests_failed++; $display("FAIL bypass_same_cycle got p=%0d pcout=%0d exp 100", p2, pcout2);
    end
    pcin = 48'd250;
    #1;
    tests_run++;
    if (p2 !== 48'd250) begin
      tests_failed++; $display("FAIL bypass_comb got %0d exp 250", p2);
    end
    for (int i = 0; i < 4; i++) begin
      opmode = (i % 2 == 0) ? 8'h44 : 8'h04;
      tick();
      tests_run++;
      if (p !== 48'd250 || p2 !== 48'd250 || carryout !== 1'b0) begin
        tests_failed++; $display("FAIL rsvd_bit[%0d] got p=%0d p2=%0d co=%b exp 250/250/0", i, p, p2, carryout);
      end
    end
  endtask

  task automatic test_random();
    logic [PW:0] comb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      ce_opmode  = ($urandom_range(0, 3) != 0);
      ce_carryin = ($urandom_range(0, 3) != 0);
      ce_p       = ($urandom_range(0, 3) != 0);
      opmode     = 8'($urandom());
      carryin    = 1'($urandom());
      m          = MW'({$urandom(), $urandom()});
      dab        = PW'({$urandom(), $urandom()});
      pcin       = PW'({$urandom(), $urandom()});
      c          = ($urandom_range(0, 7) == 0) ? {PW{1'b1}} : PW'({$urandom(), $urandom()});
      tick();
      tests_run++;
      if (p !== mdl_p || pcout !== mdl_p || carryout !== mdl_co || carryoutf !== mdl_co) begin
        tests_failed++;
        $display("FAIL rand_preg[%0d] got p=%h co=%b exp p=%h co=%b", i, p, carryout, mdl_p, mdl_co);
      end
      comb = ref_calc();
      tests_run++;
      if (p2 !== comb[PW-1:0] || pcout2 !== comb[PW-1:0] || carryout2 !== mdl_co) begin
        tests_failed++;
        $display("FAIL rand_bypass[%0d] got p=%h co=%b exp p=%h co=%b", i, p2, carryout2, comb[PW-1:0], mdl_co);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mac();
    test_enable_hold();
    test_subtract();
    test_wrap_carry();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d tests", tests_run);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP slice.
- Sits directly downstream of the M (product) register stage and the C/D:A:B register stages; consumes their registered or bypassed outputs.
- Selects X and Z operands by opmode, computes Z ± (X + CIN), and registers the result into P with carry-out.
- P feeds back internally for multiply-accumulate and cascades out on PCOUT.

Parameters:
- PWIDTH, 48, width of P/C/PCIN/DAB datapath.
- MWIDTH, 36, width of multiplier product input m.
- OPMODEREG, 1, 1 = opmode registered (ce_opmode), 0 = opmode used combinationally.
- CARRYINREG, 1, 1 = selected carry-in registered (ce_carryin), 0 = bypassed.
- PREG, 1, 1 = p/pcout driven from P register, 0 = driven from adder output.
- CARRYOUTREG, 1, 1 = carryout registered (ce_p), 0 = bypassed.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset for all internal registers
- ce_opmode  input  1  clock enable, opmode register
- ce_carryin  input  1  clock enable, carry-in register
- ce_p  input  1  clock enable, P and carry-out registers
- opmode  input  8  [1:0] X sel, [3:2] Z sel, [4] CIN constant, [5] CIN source, [6] reserved/ignored, [7] subtract
- m  input  MWIDTH  product from M stage
- dab  input  PWIDTH  concatenated {D[11:0],A,B} from upstream
- c  input  PWIDTH  C operand
- pcin  input  PWIDTH  cascade input from previous slice
- carryin  input  1  external carry input
- p  output  PWIDTH  result
- pcout  output  PWIDTH  cascade out, always equal to p
- carryout  output  1  adder carry/borrow out
- carryoutf  output  1  fabric copy, always equal to carryout

Behaviour:
- Clock and reset: all registers update on posedge clk. rst=1 clears opmode_r, cyi, P and carryout registers to 0. rst has priority over every ce. With ce low, a register holds its value.
- Reset outputs: after reset, p=0, pcout=0, carryout=0 and carryoutf=0 when PREG=CARRYOUTREG=1.
- X mux (opmode[1:0]):
  - 00 → 0
  - 01 → m zero-extended to PWIDTH
  - 10 → P register
  - 11 → dab
- Z mux (opmode[3:2]):
  - 00 → 0
  - 01 → pcin
  - 10 → P register
  - 11 → c
- P feedback: always taken from the internal P register, which is clocked (ce_p, rst) independent of PREG. This gives no combinational loop when PREG=0.
- Carry select: cin_sel = opmode[5] ? carryin : opmode[4]. With CARRYINREG=1, cyi captures cin_sel on ce_carryin and cyi feeds the adder. Otherwise cin_sel feeds the adder directly.
- Arithmetic: PWIDTH+1-bit unsigned.
  - add: sum = {0,Z} + {0,X} + cin
  - subtract (opmode[7]=1): sum = {0,Z} − ({0,X} + cin)
  - Result is sum[PWIDTH-1:0], wrapping mod 2^PWIDTH.
  - carry = sum[PWIDTH]; for subtract this is the borrow (1 when Z < X+cin).
- Latency: with OPMODEREG=1, opmode presented in cycle n controls the add whose result is clocked into P at the end of cycle n+1, matching the upstream M register. Data inputs m/dab/c/pcin are used in the cycle they are presented. With PREG=1, p updates 1 clk after the add; with PREG=0, p is combinational from the adder.
- Simultaneous events: rst together with ce_p=1 clears P; the accumulation is lost.
- Reset mid-accumulation: the next cycle's feedback reads 0.
- Reserved opmode[6]: must not affect any output.

Decomposition:
- Shared package: opmode field bit positions, X/Z select encodings (ZERO, M, P, DAB / ZERO, PCIN, P, C), default PWIDTH/MWIDTH.
- Sub-module: reuse the team's register/bypass cell dff_mux (RSTTYPE="SYNC", SEL from the *REG parameters) for the opmode, cyi, P and carryout registers.
- P feedback uses the dff_mux internal register output, so dff_mux gains or exposes a REG_OUT port; the bypass path stays unchanged.

Test Plan:
1. Reset: rst=1 for 2 clks with all ce=1 and m=5 → p=0, carryout=0 throughout and on the first clk after release, before new data lands.
2. MAC: opmode X=M, Z=P, add, cin=0; m=3 for 4 cycles, ce_p=1 → p=3, 6, 9, 12 on successive clks, respecting OPMODEREG alignment.
3. Subtract with borrow: Z=C, X=M, sub, c=5, m=7, cin=0 → p=2^48−2, carryout=1. Same with c=7, m=5 → p=2, carryout=0.
4. Wrap/carry: Z=C=2^48−1, X=DAB=1, add → p=0, carryout=1. With opmode[5]=1, carryin=1, dab=0, CARRYINREG=1 → the carry affects P one clk later.
5. Enable hold: mid-MAC drop ce_p for 3 clks → p frozen. Drop ce_opmode while changing opmode → old X/Z select still used.
6. Cascade/bypass: PREG=0, Z=PCIN=100, X=0 → p=pcout=100 in the same cycle. Opmode[6] toggling → no output change.
